// File: rtl/morse_decoder.sv
// Morse receive decoder: synchronises the serial on/off line, samples it once
// per Morse unit at mid-unit, classifies marks and spaces, and emits the 3-bit
// code of letters S..Z when the end-of-letter gap is seen.
module morse_decoder #(
  parameter int UNIT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       morse_in,
  output logic       letter_valid,
  output logic [2:0] letter,
  output logic       letter_err,
  output logic       busy
);

  localparam int TW = $clog2(UNIT_CYCLES);
  localparam logic [TW-1:0] T_HALF = TW'(UNIT_CYCLES / 2);
  localparam logic [TW-1:0] T_FULL = TW'(UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t          state;
  logic            sync_p0, s_in, s_in_d;
  logic [TW-1:0]   timer;
  logic [2:0]      mark_len;
  logic [1:0]      space_len;
  logic [2:0]      sym_cnt;
  logic [3:0]      sym;
  logic            err_acc;

  logic            rise;
  logic            strobe;
  logic [1:0]      cls;
  logic [3:0]      dec;

  // Mark length to symbol: {bad, symbol}; 1 unit is a dot, 3 units a dash.
  function automatic logic [1:0] classify_mark(input logic [2:0] len);
    logic [1:0] r;
    case (len)
      3'd1:    r = 2'b00;
      3'd3:    r = 2'b01;
      default: r = 2'b10;
    endcase
    return r;
  endfunction

  // Pattern to letter: {err, letter[2:0]}; anything unrecognised is an error.
  function automatic logic [3:0] decode_letter(input logic [2:0] cnt,
                                               input logic [3:0] pat,
                                               input logic       err);
    logic [3:0] r;
    r = 4'b1000;
    case (cnt)
      3'd1: if (pat[0]) r = 4'b0001;
      3'd3: begin
        case (pat[2:0])
          3'b000:  r = 4'b0000;
          3'b001:  r = 4'b0010;
          3'b011:  r = 4'b0100;
          default: r = 4'b1000;
        endcase
      end
      3'd4: begin
        case (pat)
          4'b0001: r = 4'b0011;
          4'b1001: r = 4'b0101;
          4'b1011: r = 4'b0110;
          4'b1100: r = 4'b0111;
          default: r = 4'b1000;
        endcase
      end
      default: r = 4'b1000;
    endcase
    if (err) r = 4'b1000;
    return r;
  endfunction

  assign rise   = s_in & ~s_in_d;
  assign strobe = (state != IDLE) && (timer == '0);
  assign cls    = classify_mark(mark_len);
  assign dec    = decode_letter(sym_cnt, sym, err_acc);

  // Two-flop synchroniser on the asynchronous line, plus a delayed copy for edge detect.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      s_in    <= 1'b0;
      s_in_d  <= 1'b0;
    end else begin
      sync_p0 <= morse_in;
      s_in    <= sync_p0;
      s_in_d  <= s_in;
    end
  end

  // Decoder FSM with mid-unit sample timer and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      mark_len     <= '0;
      space_len    <= '0;
      sym_cnt      <= '0;
      sym          <= '0;
      err_acc      <= 1'b0;
      letter_valid <= 1'b0;
      letter       <= '0;
      letter_err   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      if (state != IDLE) timer <= strobe ? T_FULL : timer - 1'b1;
      case (state)
        IDLE: begin
          if (rise) begin
            state    <= MARK;
            busy     <= 1'b1;
            timer    <= T_HALF;
            mark_len <= '0;
            sym_cnt  <= '0;
            sym      <= '0;
            err_acc  <= 1'b0;
          end
        end
        MARK: begin
          if (strobe) begin
            if (s_in) begin
              if (mark_len != 3'd4) mark_len <= mark_len + 3'd1;
            end else begin
              sym <= {sym[2:0], cls[0]};
              if (cls[1] || sym_cnt == 3'd4) err_acc <= 1'b1;
              if (sym_cnt != 3'd4) sym_cnt <= sym_cnt + 3'd1;
              space_len <= 2'd1;
              state     <= SPACE;
            end
          end
        end
        SPACE: begin
          if (strobe) begin
            if (s_in) begin
              if (space_len == 2'd2) err_acc <= 1'b1;
              mark_len <= 3'd1;
              state    <= MARK;
            end else if (space_len == 2'd2) begin
              letter_err   <= dec[3];
              letter       <= dec[2:0];
              letter_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= IDLE;
            end else begin
              space_len <= space_len + 2'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
